// File: rtl/kbd_pkg.sv
// Shared constants, FSM encoding and event layout for the keyboard event controller.
package kbd_pkg;

   localparam logic [7:0] SC_E0      = 8'hE0;
   localparam logic [7:0] SC_F0      = 8'hF0;
   localparam logic [7:0] SC_LSHIFT  = 8'h12;
   localparam logic [7:0] SC_RSHIFT  = 8'h59;
   localparam logic [7:0] SC_CTRL    = 8'h14;
   localparam logic [7:0] SC_ALT     = 8'h11;
   localparam logic [7:0] SC_CAPS    = 8'h58;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StPop    = 2'd1,
      StDecode = 2'd2
   } kbd_state_e;

   localparam int unsigned EV_W     = 14;
   localparam int unsigned EV_CAPS  = 13;
   localparam int unsigned EV_ALT   = 12;
   localparam int unsigned EV_CTRL  = 11;
   localparam int unsigned EV_SHIFT = 10;
   localparam int unsigned EV_BRK   = 9;
   localparam int unsigned EV_EXT   = 8;

   // mods is ordered {caps, alt, ctrl, shift}, matching event bits [13:10].
   function automatic logic [EV_W-1:0] pack_event(input logic [3:0] m, input logic brk,
                                                   input logic ext, input logic [7:0] code);
      return {m, brk, ext, code};
   endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module kbd_evt_fifo #(
   parameter int unsigned Width = 14,
   parameter int unsigned Depth = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [AW:0]      wptr_q, rptr_q;
   logic             do_pop, do_push;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rptr_q[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
            wptr_q                <= wptr_q + 1'b1;
         end
         if (do_pop) rptr_q <= rptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/kbd_event_ctrl.sv
// Pops bytes from the PS/2 receiver, folds E0/F0 prefixes into key events, tracks modifiers,
// filters typematic repeats and queues events for the consumer.
module kbd_event_ctrl
   import kbd_pkg::*;
#(
   parameter int unsigned DEPTH         = 8,
   parameter bit          FILTER_REPEAT = 1'b1
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [7:0]      ps2code,
   input  logic            ready,
   input  logic            overflow,
   output logic            nextdata_n,
   output logic [EV_W-1:0] ev_data,
   output logic            ev_valid,
   input  logic            ev_rd,
   output logic [3:0]      mods,
   output logic            err_ovf,
   input  logic            err_clr,
   output logic [7:0]      drop_cnt
);

   kbd_state_e state_q;
   logic [7:0] byte_q;
   logic       nextdata_n_q;
   logic       ext_p_q, brk_p_q;
   logic       lshift_q, rshift_q, ctrl_q, alt_q, caps_q;
   logic       lshift_d, rshift_d, ctrl_d, alt_d, caps_d;
   logic [8:0] held_q, key;
   logic       held_v_q;
   logic       err_ovf_q;
   logic [7:0] drop_cnt_q;

   logic            is_e0, is_f0, is_rep, push, pop, drop;
   logic            fifo_full, fifo_empty;
   logic [EV_W-1:0] ev_word;

   always_comb begin
      is_e0    = (byte_q == SC_E0);
      is_f0    = (byte_q == SC_F0);
      key      = {ext_p_q, byte_q};
      is_rep   = !brk_p_q && held_v_q && (held_q == key);
      lshift_d = lshift_q;
      rshift_d = rshift_q;
      ctrl_d   = ctrl_q;
      alt_d    = alt_q;
      caps_d   = caps_q;
      case (byte_q)
         SC_LSHIFT: lshift_d = !brk_p_q;
         SC_RSHIFT: rshift_d = !brk_p_q;
         SC_CTRL:   ctrl_d   = !brk_p_q;
         SC_ALT:    alt_d    = !brk_p_q;
         SC_CAPS:   if (!brk_p_q && !ext_p_q && !is_rep) caps_d = !caps_q;
         default:   ;
      endcase
      ev_word = pack_event({caps_d, alt_d, ctrl_d, lshift_d | rshift_d}, brk_p_q, ext_p_q,
                           byte_q);
      push    = (state_q == StDecode) && !is_e0 && !is_f0 && (!is_rep || !FILTER_REPEAT);
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= StIdle;
         byte_q       <= '0;
         nextdata_n_q <= 1'b1;
         ext_p_q      <= 1'b0;
         brk_p_q      <= 1'b0;
         lshift_q     <= 1'b0;
         rshift_q     <= 1'b0;
         ctrl_q       <= 1'b0;
         alt_q        <= 1'b0;
         caps_q       <= 1'b0;
         held_q       <= '0;
         held_v_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (ready) begin
                  byte_q       <= ps2code;
                  nextdata_n_q <= 1'b0;
                  state_q      <= StPop;
               end
            end
            StPop: begin
               nextdata_n_q <= 1'b1;
               state_q      <= StDecode;
            end
            StDecode: begin
               state_q <= StIdle;
               if (is_e0) begin
                  ext_p_q <= 1'b1;
               end else if (is_f0) begin
                  brk_p_q <= 1'b1;
               end else begin
                  lshift_q <= lshift_d;
                  rshift_q <= rshift_d;
                  ctrl_q   <= ctrl_d;
                  alt_q    <= alt_d;
                  caps_q   <= caps_d;
                  if (!brk_p_q) begin
                     held_q   <= key;
                     held_v_q <= 1'b1;
                  end else if (held_v_q && (held_q == key)) begin
                     held_v_q <= 1'b0;
                  end
                  ext_p_q <= 1'b0;
                  brk_p_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign pop  = ev_rd && ev_valid;
   assign drop = push && fifo_full && !pop;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         err_ovf_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else if (err_clr) begin
         err_ovf_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         if (overflow) err_ovf_q <= 1'b1;
         if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   kbd_evt_fifo #(
      .Width(EV_W),
      .Depth(DEPTH)
   ) u_fifo (
      .clk_i  (clk),
      .rst_i  (clr),
      .push_i (push),
      .wdata_i(ev_word),
      .pop_i  (ev_rd),
      .rdata_o(ev_data),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   assign ev_valid   = !fifo_empty;
   assign nextdata_n = nextdata_n_q;
   assign mods       = {caps_q, alt_q, ctrl_q, lshift_q | rshift_q};
   assign err_ovf    = err_ovf_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Bench for kbd_event_ctrl: directed scenarios plus a random byte stream against a reference model.
module tb_kbd_event_ctrl;

   localparam int unsigned DEPTH = 8;
   localparam bit          FILT  = 1'b1;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [7:0]  ps2code = '0;
   logic        ready = 1'b0, overflow = 1'b0, ev_rd = 1'b0, err_clr = 1'b0;
   logic        nextdata_n, ev_valid, err_ovf;
   logic [13:0] ev_data;
   logic [3:0]  mods;
   logic [7:0]  drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int pulses  = 0;

   kbd_event_ctrl #(
      .DEPTH(DEPTH),
      .FILTER_REPEAT(FILT)
   ) dut (
      .clk(clk), .clr(clr), .ps2code(ps2code), .ready(ready), .overflow(overflow),
      .nextdata_n(nextdata_n), .ev_data(ev_data), .ev_valid(ev_valid), .ev_rd(ev_rd),
      .mods(mods), .err_ovf(err_ovf), .err_clr(err_clr), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (!nextdata_n) pulses++;

   // Reference model: key-level state, not cycle-level.
   logic [13:0] mq[$];
   bit          m_ls, m_rs, m_ctl, m_alt, m_caps, m_ext, m_brk, m_hv, m_err;
   logic [8:0]  m_held;
   int          m_drop;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      {m_ls, m_rs, m_ctl, m_alt, m_caps, m_ext, m_brk, m_hv, m_err} = '0;
      m_held = '0;
      m_drop = 0;
   endtask

   task automatic model_apply(input logic [7:0] b);
      bit rep, mk;
      if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else begin
         mk  = !m_brk;
         rep = mk && m_hv && (m_held == {m_ext, b});
         if (mk) begin
            m_held = {m_ext, b};
            m_hv   = 1;
         end else if (m_hv && m_held == {m_ext, b}) begin
            m_hv = 0;
         end
         if (b == 8'h12) m_ls = mk;
         if (b == 8'h59) m_rs = mk;
         if (b == 8'h14) m_ctl = mk;
         if (b == 8'h11) m_alt = mk;
         if (b == 8'h58 && mk && !m_ext && !rep) m_caps = !m_caps;
         if (!rep || !FILT) begin
            if (mq.size() < DEPTH) mq.push_back({m_caps, m_alt, m_ctl, m_ls | m_rs, m_brk, m_ext, b});
            else if (m_drop < 255) m_drop++;
         end
         m_ext = 0;
         m_brk = 0;
      end
   endtask

   task automatic compare_state();
      check("ev_valid", ev_valid, mq.size() != 0);
      if (mq.size() != 0) check("ev_head", ev_data, mq[0]);
      check("mods", mods, {m_caps, m_alt, m_ctl, m_ls | m_rs});
      check("drop_cnt", drop_cnt, m_drop);
      check("err_ovf", err_ovf, m_err);
   endtask

   // Offers one byte like ps2_keyboard would; rd asserts ev_rd on the decode edge.
   task automatic send_byte(input logic [7:0] b, input bit rd);
      bit seen = 0;
      ps2code = b;
      ready   = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (!nextdata_n) seen = 1;
      end
      check("pop_seen", seen, 1);
      ready = 1'b0;
      if (!seen) return;
      @(negedge clk);
      check("pop_width", nextdata_n, 1);
      ev_rd = rd;
      @(negedge clk);
      ev_rd = 1'b0;
      if (rd && mq.size() != 0) void'(mq.pop_front());
      model_apply(b);
      compare_state();
   endtask

   task automatic drain();
      while (mq.size() != 0) begin
         check("drain_valid", ev_valid, 1);
         check("drain_data", ev_data, mq[0]);
         ev_rd = 1'b1;
         @(negedge clk);
         ev_rd = 1'b0;
         void'(mq.pop_front());
      end
      check("drain_empty", ev_valid, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_reset();
   endtask

   logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58,
                             8'h1C, 8'h1B, 8'h75, 8'hE0};
   logic [7:0] keys [10] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43,
                             8'h44, 8'h4D};

   initial begin
      int p0;
      do_reset();
      check("rst_nextdata_n", nextdata_n, 1);
      check("rst_valid", ev_valid, 0);
      check("rst_data", ev_data, 0);
      check("rst_mods", mods, 0);
      check("rst_err", err_ovf, 0);
      check("rst_drop", drop_cnt, 0);

      p0 = pulses;
      send_byte(8'h1C, 0); send_byte(8'hF0, 0); send_byte(8'h1C, 0);
      check("pulse_count", pulses - p0, 3);
      drain();

      send_byte(8'hE0, 0); send_byte(8'h75, 0);
      send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
      drain();

      send_byte(8'h12, 0); send_byte(8'h1C, 0); send_byte(8'hF0, 0); send_byte(8'h1C, 0);
      send_byte(8'hF0, 0); send_byte(8'h12, 0);
      check("mods_end", mods, 0);
      drain();

      send_byte(8'h58, 0); send_byte(8'h58, 0); send_byte(8'hF0, 0); send_byte(8'h58, 0);
      send_byte(8'h58, 0);
      check("caps_end", mods[3], 0);
      drain();

      for (int i = 0; i < 9; i++) send_byte(keys[i], 0);
      check("drop_one", drop_cnt, 1);
      send_byte(keys[9], 1);
      check("drop_rd_full", drop_cnt, 1);
      drain();

      @(negedge clk); overflow = 1'b1;
      @(negedge clk); overflow = 1'b0;
      m_err = 1;
      repeat (3) @(negedge clk);
      compare_state();
      err_clr = 1'b1; overflow = 1'b1;
      @(negedge clk);
      err_clr = 1'b0; overflow = 1'b0;
      m_err = 0; m_drop = 0;
      compare_state();

      send_byte(8'hF0, 0);
      do_reset();
      compare_state();
      send_byte(8'h1C, 0);
      check("clr_mid_event", ev_data, 14'h01C);
      drain();

      for (int i = 0; i < 300; i++) begin
         send_byte(pool[$urandom_range(0, 11)], $urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) drain();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/kbd_event_ctrl.md
# kbd_event_ctrl

Sequencing controller for the PS/2 receiver (`ps2_keyboard`). It owns the `nextdata_n` pop handshake and decodes the E0/F0 prefix bytes into whole key events. It tracks the modifier and caps-lock state and queues timestamp-free event words in a small FIFO for the CPU/terminal side. It sits between `ps2_keyboard` and any consumer (ASCII translator, MMIO keyboard port) and replaces ad-hoc prefix handling in consumers.

## Interface
Parameters:
- `DEPTH`, 8: event FIFO depth; power of 2, minimum 2.
- `FILTER_REPEAT`, 1: when 1, typematic repeat makes are not queued.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock.
- `clr`  in  1  asynchronous active-high reset.
- `ps2code`  in  8  byte from `ps2_keyboard`.
- `ready`  in  1  `ps2_keyboard` has a byte available.
- `overflow`  in  1  `ps2_keyboard` internal FIFO overflow.
- `nextdata_n`  out  1  active-low one-cycle pop to `ps2_keyboard`.
- `ev_data`  out  14  head event: [13] caps, [12] alt, [11] ctrl, [10] shift, [9] brk, [8] ext, [7:0] scan code.
- `ev_valid`  out  1  FIFO not empty.
- `ev_rd`  in  1  consumer pop; ignored when `ev_valid`=0.
- `mods`  out  4  live {caps, alt, ctrl, shift}.
- `err_ovf`  out  1  sticky: receiver overflow seen.
- `err_clr`  in  1  clears `err_ovf` and `drop_cnt`.
- `drop_cnt`  out  8  events lost to full FIFO; saturates at 255.

## Operation
- FSM states: IDLE, POP, DECODE.
  - IDLE: if `ready`, latch `ps2code` into `byte_q` and go to POP.
  - POP: `nextdata_n`=0 for this cycle only, then go to DECODE.
  - DECODE: process `byte_q`, then return to IDLE.
- DECODE rules:
  - E0: set `ext_p`.
  - F0: set `brk_p`.
  - Any other byte: form the event {brk_p, ext_p, byte_q}, update state, conditionally push, then clear `ext_p` and `brk_p`.
- Modifiers:
  - Shift = lshift (0x12) | rshift (0x59), tracked separately.
  - Ctrl = 0x14; alt = 0x11. Both set on make and clear on break, ext or not.
  - Caps toggles on a non-repeat make of non-ext 0x58; break has no effect.
- Repeat detection (always active):
  - `held` = {ext, code} of the last make; `held_v` marks it valid.
  - A make equal to `held` while `held_v`=1 is a repeat.
  - A break equal to `held` clears `held_v`.
  - A make of a different key replaces `held`.
  - Repeats never toggle caps. They are pushed only when `FILTER_REPEAT`=0.
- Event modifier bits [13:10] are the state after applying the current byte; e.g. shift make carries shift=1 and shift break carries shift=0.
- FIFO full on push: event dropped, `drop_cnt`+1 (saturating). Push and `ev_rd` in the same cycle while full: both succeed, no drop.
- `overflow`=1 in any cycle sets `err_ovf`. `err_clr` wins over a simultaneous set and increment.

## Timing
- Reset values:
  - `nextdata_n`=1, `ev_valid`=0, `ev_data`=0, `mods`=0, `err_ovf`=0, `drop_cnt`=0.
  - FSM in IDLE; `ext_p`=`brk_p`=`held_v`=0; FIFO pointers at 0.
- 3 cycles per PS/2 byte minimum. `nextdata_n` is low exactly 1 cycle per byte and never in consecutive cycles.
- Event visible: pushed at the DECODE clock edge, so `ev_valid` rises the next cycle. Latency is 3 cycles from `ready` sampled high to `ev_valid`.
- `ev_data` shows the FIFO head combinationally from registered storage. `ev_rd` advances it on the next edge.
- Pointers are log2(DEPTH)+1 bits; wrap is natural. Full when MSBs differ and LSBs are equal.
- `clr` mid-sequence (e.g. after F0, before the code byte) discards pending prefixes. Consumers see a clean empty state.

## Structure
- Package `kbd_pkg` holds:
  - scan-code constants SC_E0=0xE0, SC_F0=0xF0, SC_LSHIFT=0x12, SC_RSHIFT=0x59, SC_CTRL=0x14, SC_ALT=0x11, SC_CAPS=0x58;
  - FSM state encoding;
  - event bit-field positions.
- Sub-module `kbd_evt_fifo`: parameterised synchronous FIFO (width 14, `DEPTH`) with full/empty and simultaneous push/pop.

## Test plan
- Bytes 0x1C, F0 0x1C → events 0x01C then 0x21C; `nextdata_n` pulses 3 times, 1 cycle each.
- E0 0x75, E0 F0 0x75 → events 0x175 then 0x375; `ext_p` cleared after each.
- 0x12, 0x1C, F0 0x1C, F0 0x12 → events 0x412, 0x41C, 0x61C, 0x212; `mods`=0 at the end.
- 0x58, 0x58, F0 0x58, 0x58 → caps ends 0 (toggled twice, the repeat is ignored). With `FILTER_REPEAT`=1: 3 events queued, `ev_data`[13] = 1, 1, 0.
- Nine makes of distinct keys with `ev_rd`=0 and `DEPTH`=8 → 8 queued, `drop_cnt`=1. Ninth make with `ev_rd`=1 while full → no drop.
- Assert `clr` after F0 mid-stream, then send 0x1C → event 0x01C (not a break). Pulse `overflow` → `err_ovf`=1 until `err_clr`.
